// File: rtl/calc_hist.sv
// calc_hist: accumulator calculator with an undo history.
//
// Each load-button press applies the selected operation to the accumulator
// (A) and the switch value (B), pushing the previous accumulator onto a
// circular history so it can be restored with the undo button. A clear
// button zeroes the accumulator, the history count and the overflow flag.
//
// Parameters
//   W      accumulator / switch / LED width (4..32)
//   DEPTH  number of undo-history entries (power of two, 2..64)
//
// Ports
//   clk       system clock, all flops on its rising edge
//   btnac_n   asynchronous active-low reset
//   btnc      load button   (asynchronous, one action per press)
//   btnu      undo button   (asynchronous, one action per press)
//   btnclr    clear button  (asynchronous, one action per press)
//   btnl/r/d  operation select {btnl,btnr,btnd}, sampled at the action edge
//   sw        operand B, two's complement
//   led       accumulator value (registered)
//   ovf       sticky signed overflow from ADD/SUB
//   hist_cnt  number of valid history entries

module calc_hist #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       btnac_n,
    input  logic                       btnc,
    input  logic                       btnu,
    input  logic                       btnclr,
    input  logic                       btnl,
    input  logic                       btnr,
    input  logic                       btnd,
    input  logic [W-1:0]               sw,
    output logic [W-1:0]               led,
    output logic                       ovf,
    output logic [$clog2(DEPTH+1)-1:0] hist_cnt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [5:0]    W_L      = 6'(W);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_SLL = 3'b110,
        OP_SRA = 3'b111
    } op_t;

    // ------------------------------------------------------------------
    // Reset release synchroniser and button conditioning.
    // Bit order in the button vectors: {clear, undo, load}.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic [2:0] btn_raw;
    logic [2:0] btn_s1;
    logic [2:0] btn_s2;
    logic [2:0] btn_prev;
    logic [2:0] btn_arm;
    logic [2:0] btn_pulse;

    assign btn_raw = {btnclr, btnu, btnc};

    // A button is only armed once it has been seen released after reset has
    // been synchronised, so a button held through reset release (or pressed
    // when reset hit) cannot fire until it is released and pressed again.
    always_ff @(posedge clk or negedge btnac_n) begin
        if (!btnac_n) begin
            rst_sync <= '0;
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
            btn_arm  <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
            btn_s1   <= btn_raw;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
            if (rst_sync[1]) begin
                btn_arm <= btn_arm | ~btn_s2;
            end
        end
    end

    assign btn_pulse = btn_s2 & ~btn_prev & btn_arm;

    logic ld_p;
    logic undo_p;
    logic clr_p;

    assign ld_p   = btn_pulse[0];
    assign undo_p = btn_pulse[1];
    assign clr_p  = btn_pulse[2];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [W-1:0] acc;
    logic [W-1:0] alu_res;
    logic         alu_ovf;
    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic [W-1:0] prod;
    logic [4:0]   shamt;
    logic         sh_big;
    op_t          op;

    assign op = op_t'({btnl, btnr, btnd});

    generate
        if (W >= 5) begin : g_sh_wide
            assign shamt = sw[4:0];
        end else begin : g_sh_narrow
            assign shamt = {{(5 - W){1'b0}}, sw};
        end
    endgenerate

    assign sum    = acc + sw;
    assign diff   = acc - sw;
    assign prod   = acc * sw;    // low W bits are identical for signed/unsigned
    assign sh_big = ({1'b0, shamt} >= W_L);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (acc[W-1] == sw[W-1]) && (sum[W-1] != acc[W-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (acc[W-1] != sw[W-1]) && (diff[W-1] != acc[W-1]);
            end
            OP_AND: alu_res = acc & sw;
            OP_OR:  alu_res = acc | sw;
            OP_XOR: alu_res = acc ^ sw;
            OP_MUL: alu_res = prod;
            OP_SLL: alu_res = sh_big ? '0 : (acc << shamt);
            OP_SRA: alu_res = sh_big ? {W{acc[W-1]}} : W'($signed(acc) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator and history. wr_ptr points at the next free slot; the
    // most recent entry sits at wr_ptr-1. DEPTH is a power of two, so the
    // pointer wraps naturally and a push when full overwrites the oldest.
    // ------------------------------------------------------------------
    logic [W-1:0]  hist_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    assign rd_ptr = wr_ptr - PW'(1);

    always_ff @(posedge clk or negedge btnac_n) begin
        if (!btnac_n) begin
            acc    <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
            wr_ptr <= '0;
        end else if (clr_p) begin
            acc    <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
            wr_ptr <= '0;
        end else if (ld_p) begin
            acc    <= alu_res;
            wr_ptr <= wr_ptr + PW'(1);
            if (cnt != CNT_FULL) begin
                cnt <= cnt + CW'(1);
            end
            if (alu_ovf) begin
                ovf <= 1'b1;
            end
        end else if (undo_p && (cnt != '0)) begin
            acc    <= hist_mem[rd_ptr];
            wr_ptr <= rd_ptr;
            cnt    <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ld_p && !clr_p) begin
            hist_mem[wr_ptr] <= acc;
        end
    end

    assign led      = acc;
    assign hist_cnt = cnt;

endmodule

// File: doc/calc_hist.md
CALC_HIST -- requirements
Module: calc_hist

Interface
REQ-001 SHALL have parameter W, default 16: accumulator/switch/LED width, legal range 4..32.
REQ-002 SHALL have parameter DEPTH, default 8: undo-history entries, power of two, 2..64.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all flops rise-edge clk.
REQ-004 SHALL have port btnac_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port btnc, input, 1 bit: load button, asynchronous to clk.
REQ-006 SHALL have port btnu, input, 1 bit: undo button, asynchronous to clk.
REQ-007 SHALL have port btnclr, input, 1 bit: synchronous all-clear button, asynchronous to clk.
REQ-008 SHALL have ports btnl, btnr, btnd, input, 1 bit each: operation select, level-sampled.
REQ-009 SHALL have port sw, input, W bits: operand B, two's complement.
REQ-010 SHALL have port led, output, W bits: accumulator value.
REQ-011 SHALL have port ovf, output, 1 bit: sticky signed-overflow flag.
REQ-012 SHALL have port hist_cnt, output, clog2(DEPTH+1) bits: valid history entries.

Function
REQ-013 SHALL pass btnc, btnu and btnclr each through a 2-flop synchroniser plus a rising-edge detector; each press yields exactly one action pulse.
REQ-014 Latency: button high before edge E0 SHALL have its effect visible on outputs after edge E2; holding a button SHALL NOT repeat the action.
REQ-015 op = {btnl,btnr,btnd} SHALL be sampled at the action edge: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 MUL (low W bits of signed product), 110 SLL A by sw[4:0], 111 SRA A by sw[4:0].
REQ-016 Shift amounts >= W SHALL give 0 for SLL and all-copies-of-sign-bit for SRA.
REQ-017 A = accumulator, B = sw; both SHALL be treated as W-bit signed; result SHALL be truncated to W bits.
REQ-018 Load pulse SHALL push the old accumulator onto the history, then write the ALU result to the accumulator, in the same cycle.
REQ-019 History full (hist_cnt == DEPTH) on load: the oldest entry SHALL be discarded (circular overwrite); hist_cnt SHALL stay DEPTH.
REQ-020 Undo pulse with hist_cnt > 0 SHALL restore the most recent entry to the accumulator and decrement hist_cnt.
REQ-021 Undo pulse with hist_cnt == 0 SHALL be ignored; no state change.
REQ-022 ovf SHALL set on load when ADD or SUB overflows the signed W-bit range; other ops SHALL leave ovf unchanged; undo SHALL NOT alter ovf.
REQ-023 Clear pulse SHALL zero the accumulator, hist_cnt and ovf in one cycle.
REQ-024 Simultaneous pulses in one cycle SHALL resolve with priority clear > load > undo; lower-priority pulses in that cycle SHALL be dropped.
REQ-025 led SHALL be driven directly from the accumulator register (no combinational path from sw or buttons).

Reset
REQ-026 btnac_n low SHALL immediately, without clk, force accumulator=0, ovf=0, hist_cnt=0, history pointers=0, all synchroniser and edge flops=0.
REQ-027 Reset asserted mid-press SHALL cancel the pending action; a button still held at reset release SHALL NOT produce a pulse until it is released and pressed again.
REQ-028 Release of btnac_n SHALL be synchronised internally, so the first action is accepted no earlier than the second clk edge after release.

Verification
REQ-029 W=16: reset, sw=0x0005, op=000, press btnc -> led=0x0005 two edges after sampling; then sw=0x0003, op=001, press -> led=0x0002, hist_cnt=2.
REQ-030 W=16: load 0x7FFF, then sw=0x0001, op=000, press btnc -> led=0x8000, ovf=1; then op=010 load -> ovf stays 1; btnclr -> led=0, ovf=0, hist_cnt=0.
REQ-031 DEPTH=4: six loads giving 1,2,3,4,5,6 -> hist_cnt=4; five undos -> led=5,4,3,2 then stays 2, hist_cnt=0.
REQ-032 btnc held high for 100 cycles -> exactly one load; btnc and btnu pulse in the same cycle -> load only, undo dropped.
REQ-033 led=0x8000, op=111, sw=0x0004 -> led=0xF800; op=110, sw=0x0014 -> led=0x0000.
REQ-034 btnac_n pulsed low between btnc rise and its action edge -> accumulator stays 0, hist_cnt stays 0, no load after release while btnc remains high.
